// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write master: FSM states, quarter-bit phases, divider helper.
// No logic; zero latency. No handshaking in this package.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BIT   = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int NBYTES = 3;

    function automatic int quarter_div(input int clk, input int f);
        return clk / (4 * f);
    endfunction

endpackage

// File: rtl/i2c_write_master_if.sv
// Request/status and pad-side signals of the I2C write master; master = the controller, slave = its environment.
// Pure wiring: no latency. iGO is honoured only while oBUSY is low.
interface i2c_write_master_if;
    logic        iGO;
    logic [23:0] iDATA;
    logic        oBUSY;
    logic        oDONE;
    logic        oNACK;
    logic        oSCL_OE;
    logic        oSDA_OE;
    logic        iSDA;
    logic        iSCL;

    modport master (
        input  iGO, iDATA, iSDA, iSCL,
        output oBUSY, oDONE, oNACK, oSCL_OE, oSDA_OE
    );

    modport slave (
        output iGO, iDATA, iSDA, iSCL,
        input  oBUSY, oDONE, oNACK, oSCL_OE, oSDA_OE
    );
endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick divider: counts 0..Q-1 and fires on Q-1; clr restarts the count at 0.
// tick is combinational from the count; hold freezes the count at Q-1 and suppresses the tick.
module i2c_tick_gen #(
    parameter int Q = 4
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic clr,
    input  logic hold,
    output logic tick
);
    localparam int CW = $clog2(Q);
    localparam logic [CW-1:0] LAST = CW'(Q - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            if (hold) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = '0;
                tick  = 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/i2c_write_master.sv
// 3-byte I2C write (addr, sub, data) per iGO; oDONE 113*Q cycles after accept (less on NACK), iGO ignored while busy.
// Optional SCL clock stretching when I2C_CLK_STRETCH_EN is defined.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int I2C_FREQ = 100000
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    i2c_write_master_if.master bus
);
    localparam int Q = quarter_div(CLK_FREQ, I2C_FREQ);

    if (Q < 2) begin : g_q_check
        $error("i2c_write_master: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
    end

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_START = START;
    localparam logic [2:0] ST_BIT   = BIT;
    localparam logic [2:0] ST_STOP  = STOP;
    localparam logic [2:0] ST_DONE  = DONE;
    localparam logic [1:0] LAST_BYTE = 2'(NBYTES - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [3:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [23:0] data_q, data_d;
    logic        nack_q, nack_d;

    logic       accept, tick, hold;
    logic [7:0] cur_byte;
    logic       cur_bit;

    assign accept = bus.iGO && (state_q == ST_IDLE || state_q == ST_DONE);

`ifdef I2C_CLK_STRETCH_EN
    // A slave holding SCL low freezes the quarter-bit clock wherever we have released SCL.
    assign hold = !bus.iSCL &&
                  ((state_q == ST_BIT  && (phase_q == Q1 || phase_q == Q2)) ||
                   (state_q == ST_STOP &&  phase_q == Q1));
`else
    logic unused_scl;
    assign unused_scl = bus.iSCL;
    assign hold = 1'b0;
`endif

    i2c_tick_gen #(.Q(Q)) u_tick (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .clr    (accept),
        .hold   (hold),
        .tick   (tick)
    );

    always_comb begin
        case (byte_q)
            2'd0:    cur_byte = data_q[23:16];
            2'd1:    cur_byte = data_q[15:8];
            default: cur_byte = data_q[7:0];
        endcase
        cur_bit = cur_byte[3'd7 - bit_q[2:0]];
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        data_d  = data_q;
        nack_d  = nack_q;
        case (state_q)
            ST_START: if (tick) begin
                if (phase_q == Q1) begin
                    state_d = ST_BIT;
                    phase_d = Q0;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            ST_BIT: if (tick) begin
                if (phase_q == Q2 && bit_q == 4'd8 && bus.iSDA) nack_d = 1'b1;
                if (phase_q == Q3) begin
                    phase_d = Q0;
                    if (bit_q == 4'd8) begin
                        bit_d = 4'd0;
                        if (nack_q || byte_q == LAST_BYTE) state_d = ST_STOP;
                        else                               byte_d  = byte_q + 2'd1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            ST_STOP: if (tick) begin
                if (phase_q == Q2) state_d = ST_DONE;
                else               phase_d = phase_q + 2'd1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Accept overrides the DONE->IDLE return so back-to-back requests lose no cycle.
        if (accept) begin
            state_d = ST_START;
            phase_d = Q0;
            bit_d   = 4'd0;
            byte_d  = 2'd0;
            data_d  = bus.iDATA;
            nack_d  = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
            phase_q <= Q0;
            bit_q   <= 4'd0;
            byte_q  <= 2'd0;
            data_q  <= 24'd0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
            nack_q  <= nack_d;
        end
    end

    // Pad enables decode straight from state so an async reset releases the bus at once.
    always_comb begin
        bus.oSCL_OE = 1'b0;
        bus.oSDA_OE = 1'b0;
        case (state_q)
            ST_START: bus.oSDA_OE = (phase_q == Q1);
            ST_BIT: begin
                bus.oSCL_OE = (phase_q == Q0 || phase_q == Q3);
                bus.oSDA_OE = (bit_q != 4'd8) && !cur_bit;
            end
            ST_STOP: begin
                bus.oSCL_OE = (phase_q == Q0);
                bus.oSDA_OE = (phase_q != Q2);
            end
            default: ;
        endcase
    end

    assign bus.oBUSY = (state_q == ST_START) || (state_q == ST_BIT) || (state_q == ST_STOP);
    assign bus.oDONE = (state_q == ST_DONE);
    assign bus.oNACK = nack_q;
endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench for i2c_write_master at Q=4 with an ACKing slave model; build with I2C_CLK_STRETCH_EN
// defined to exercise the stretch path (expected latency adapts to the macro).
module tb_i2c_write_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_write_master_if bus ();

    logic slave_pull = 1'b0;
    logic scl_force  = 1'b0;
    assign bus.iSDA = ~(bus.oSDA_OE | slave_pull);
    assign bus.iSCL = ~(bus.oSCL_OE | scl_force);

    i2c_write_master #(.CLK_FREQ(400), .I2C_FREQ(25)) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus.master)
    );

    int tests = 0;
    int fails = 0;

    int          nack_byte   = 3;
    logic        stretch_arm = 1'b0;
    int          n_rise      = 0;
    logic [63:0] cap         = '0;
    int          force_cnt   = 0;
    logic        prev_scl    = 1'b0;
    logic        prev_busy   = 1'b0;

`ifdef I2C_CLK_STRETCH_EN
    localparam int STRETCH_CYC = 502;
`else
    localparam int STRETCH_CYC = 452;
`endif

    // Slave acknowledge window: from SCL fall after the 8th pulse of a byte to SCL fall after the 9th.
    function automatic logic pull_for(input int n, input logic scl_oe, input logic busy, input int nb);
        if (!busy) return 1'b0;
        if (n % 9 == 8 && scl_oe && (n / 9) != nb) return 1'b1;
        if (n > 0 && n % 9 == 0 && !scl_oe && (n / 9 - 1) != nb) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        int n;
        logic [63:0] c;
        int fc;
        n  = n_rise;
        c  = cap;
        fc = force_cnt;
        if (bus.oBUSY && !prev_busy) begin
            n = 0;
            c = '0;
        end
        if (fc > 0) fc = fc - 1;
        if (prev_scl && !bus.oSCL_OE) begin
            n = n + 1;
            c = {c[62:0], ~(bus.oSDA_OE | slave_pull)};
            if (stretch_arm && n == 6) fc = 53;
        end
        n_rise     <= n;
        cap        <= c;
        force_cnt  <= fc;
        scl_force  <= (fc > 0);
        slave_pull <= pull_for(n, bus.oSCL_OE, bus.oBUSY, nack_byte);
        prev_scl   <= bus.oSCL_OE;
        prev_busy  <= bus.oBUSY;
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected SDA levels at each SCL rise (data MSB first, then ACK bit), STOP rise excluded.
    function automatic logic [63:0] exp_bits(input logic [23:0] d, input int nb);
        logic [63:0] acc;
        int nbytes;
        acc = '0;
        nbytes = (nb < 3) ? nb + 1 : 3;
        for (int b = 0; b < nbytes; b++) begin
            for (int i = 0; i < 8; i++) acc = {acc[62:0], d[23 - 8 * b - i]};
            acc = {acc[62:0], (b == nb)};
        end
        return acc;
    endfunction

    task automatic wait_done(output int cyc, output logic busy_ok);
        cyc = 0;
        busy_ok = bus.oBUSY;
        while (!bus.oDONE && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (!bus.oDONE && !bus.oBUSY) busy_ok = 1'b0;
        end
    endtask

    task automatic go_and_wait(input logic [23:0] d, input int nb, output int cyc, output logic busy_ok);
        @(negedge clk);
        nack_byte = nb;
        bus.iDATA = d;
        bus.iGO   = 1'b1;
        @(posedge clk); #1;
        bus.iGO = 1'b0;
        wait_done(cyc, busy_ok);
    endtask

    typedef struct {
        logic [23:0] data;
        int          nb;
        int          cyc;
        logic        nack;
        int          rises;
    } vec_t;

    vec_t vt[5];

    initial begin
        int   cyc;
        logic bok;

        vt[0] = '{24'h729803, 3, 452, 1'b0, 28};
        vt[1] = '{24'h729803, 0, 164, 1'b1, 10};
        vt[2] = '{24'hA53CFF, 1, 308, 1'b1, 19};
        vt[3] = '{24'h00FF00, 2, 452, 1'b1, 28};
        vt[4] = '{24'hFFFFFF, 3, 452, 1'b0, 28};

        bus.iGO   = 1'b0;
        bus.iDATA = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.oBUSY, bus.oDONE, bus.oNACK, bus.oSCL_OE, bus.oSDA_OE}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int v = 0; v < 5; v++) begin
            go_and_wait(vt[v].data, vt[v].nb, cyc, bok);
            check($sformatf("v%0d_done_cycle", v), cyc, vt[v].cyc);
            check($sformatf("v%0d_nack", v), bus.oNACK, vt[v].nack);
            check($sformatf("v%0d_busy_held", v), bok, 1'b1);
            check($sformatf("v%0d_scl_rises", v), n_rise, vt[v].rises);
            check($sformatf("v%0d_sda_bits", v), cap >> 1, exp_bits(vt[v].data, vt[v].nb));
            repeat (5) @(posedge clk);
            #1;
            check($sformatf("v%0d_nack_held", v), {bus.oNACK, bus.oBUSY}, {vt[v].nack, 1'b0});
        end

        // iGO while busy is ignored; iGO in the oDONE cycle starts the next write.
        @(negedge clk);
        nack_byte = 3;
        bus.iDATA = 24'h729803;
        bus.iGO   = 1'b1;
        @(posedge clk); #1;
        bus.iGO = 1'b0;
        cyc = 0;
        while (!bus.oDONE && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 10 || cyc == 200) begin
                bus.iGO   = 1'b1;
                bus.iDATA = 24'h123456;
            end else begin
                bus.iGO = 1'b0;
            end
        end
        check("busy_ignore_done_cycle", cyc, 452);
        check("busy_ignore_sda_bits", cap >> 1, exp_bits(24'h729803, 3));
        bus.iDATA = 24'h729803;
        bus.iGO   = 1'b1;
        @(posedge clk); #1;
        bus.iGO = 1'b0;
        check("b2b_busy_next_cycle", bus.oBUSY, 1'b1);
        wait_done(cyc, bok);
        check("b2b_done_cycle", cyc, 452);
        repeat (3) @(posedge clk);

        // Asynchronous reset mid byte releases the bus immediately.
        @(negedge clk);
        bus.iDATA = 24'h729803;
        bus.iGO   = 1'b1;
        @(posedge clk); #1;
        bus.iGO = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_released", {bus.oSCL_OE, bus.oSDA_OE, bus.oBUSY, bus.oDONE}, 4'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        go_and_wait(24'h729803, 3, cyc, bok);
        check("after_reset_done_cycle", cyc, 452);
        check("after_reset_nack", bus.oNACK, 1'b0);

        // SCL held low by the slave during the 6th data pulse of byte 0.
        repeat (3) @(posedge clk);
        stretch_arm = 1'b1;
        go_and_wait(24'h729803, 3, cyc, bok);
        stretch_arm = 1'b0;
        check("stretch_done_cycle", cyc, STRETCH_CYC);
        check("stretch_sda_bits", cap >> 1, exp_bits(24'h729803, 3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
